// File: rtl/bls_pkg.sv
// Shared constants and per-stage control payload for the pipelined
// borrow/carry-lookahead adder-subtractor.
package bls_pkg;

   localparam logic MODE_SUB = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // Width-independent part of the per-stage payload; the operand and
   // result vectors are appended by the top level, which knows WIDTH.
   typedef struct packed {
      logic valid;
      logic mode;
      logic carry;
      logic zero_acc;
   } bls_ctrl_t;

endpackage

// File: rtl/bls_slice.sv
// Combinational STAGE_W-bit lookahead slice; the same generate/propagate
// recurrence serves both borrow (subtract) and carry (add).
module bls_slice
   import bls_pkg::*;
#(
   parameter int STAGE_W = 4
) (
   input  logic [STAGE_W-1:0] x,
   input  logic [STAGE_W-1:0] y,
   input  logic               cin,
   input  logic               mode,
   output logic [STAGE_W-1:0] d,
   output logic               cout,
   output logic               all_zero
);

   logic [STAGE_W-1:0] g;
   logic [STAGE_W-1:0] p;
   logic [STAGE_W:0]   c;

   // Subtract generates a borrow where x=0,y=1 and propagates where x==y.
   always_comb begin
      if (mode == MODE_ADD) begin
         g = x & y;
         p = x ^ y;
      end else begin
         g = ~x & y;
         p = ~(x ^ y);
      end
      c[0] = cin;
      for (int i = 0; i < STAGE_W; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
      d        = x ^ y ^ c[STAGE_W-1:0];
      cout     = c[STAGE_W];
      all_zero = ~|d;
   end

endmodule

// File: rtl/bls_pipe_addsub.sv
// Skewed pipeline of lookahead slices: stage k resolves slice k using the
// borrow/carry registered by stage k-1, with a valid/ready output register.
module bls_pipe_addsub
   import bls_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int STAGE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             mode,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             ovf
);

   localparam int NSTAGE = WIDTH / STAGE_W;

   typedef struct packed {
      bls_ctrl_t        ctrl;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] res;
   } stage_t;

   stage_t stg [NSTAGE];
   stage_t nxt [NSTAGE];
   stage_t head;
   stage_t last;
   logic   advance;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;
   assign last     = stg[NSTAGE-1];

   assign head = '{ctrl: '{valid: in_valid, mode: mode, carry: bin, zero_acc: 1'b1},
                   x: x, y: y, res: '0};

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      stage_t             src;
      logic [STAGE_W-1:0] d;
      logic               cout;
      logic               allz;
      logic [WIDTH-1:0]   res_k;

      if (k == 0) begin : g_head
         assign src = head;
      end else begin : g_body
         assign src = stg[k-1];
      end

      bls_slice #(.STAGE_W(STAGE_W)) u_slice (
         .x        (src.x[k*STAGE_W +: STAGE_W]),
         .y        (src.y[k*STAGE_W +: STAGE_W]),
         .cin      (src.ctrl.carry),
         .mode     (src.ctrl.mode),
         .d        (d),
         .cout     (cout),
         .all_zero (allz)
      );

      // Splice this stage's finished slice into the result travelling down the pipe.
      always_comb begin
         res_k = src.res;
         res_k[k*STAGE_W +: STAGE_W] = d;
      end

      assign nxt[k] = '{ctrl: '{valid: src.ctrl.valid, mode: src.ctrl.mode,
                                carry: cout, zero_acc: src.ctrl.zero_acc & allz},
                        x: src.x, y: src.y, res: res_k};
   end

   // Whole pipe shifts in lock-step; a stalled consumer freezes every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSTAGE; k++) begin
            stg[k] <= '0;
         end
         out_valid <= 1'b0;
         diff      <= '0;
         bout      <= 1'b0;
         zero      <= 1'b0;
         ovf       <= 1'b0;
      end else if (advance) begin
         for (int k = 0; k < NSTAGE; k++) begin
            stg[k] <= nxt[k];
         end
         out_valid <= last.ctrl.valid;
         diff      <= last.res;
         bout      <= last.ctrl.carry;
         zero      <= last.ctrl.zero_acc;
         if (last.ctrl.mode == MODE_ADD) begin
            ovf <= (last.x[WIDTH-1] == last.y[WIDTH-1]) && (last.res[WIDTH-1] != last.x[WIDTH-1]);
         end else begin
            ovf <= (last.x[WIDTH-1] != last.y[WIDTH-1]) && (last.res[WIDTH-1] != last.x[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_bls_pipe_addsub.sv
// Directed testbench for bls_pipe_addsub (16-bit, 4-bit stages, latency 4):
// flags, ripple, overflow, backpressure and mid-flight reset.
module tb_bls_pipe_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        mode;
   logic [15:0] x;
   logic [15:0] y;
   logic        bin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        bout;
   logic        zero;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   logic [15:0] vx [8];
   logic [15:0] vy [8];
   logic        vm [8];
   logic        vb [8];

   bls_pipe_addsub #(.WIDTH(16), .STAGE_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .x         (x),
      .y         (y),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .zero      (zero),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic m, input logic [15:0] a, input logic [15:0] b, input logic c);
      in_valid = 1'b1;
      mode     = m;
      x        = a;
      y        = b;
      bin      = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitResult(input string tag, input logic [15:0] eDiff, input logic eBout,
                             input logic eZero, input logic eOvf);
      int n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput({tag, "_lat"}, n, 4);
      checkOutput({tag, "_diff"}, diff, eDiff);
      checkOutput({tag, "_bout"}, bout, eBout);
      checkOutput({tag, "_zero"}, zero, eZero);
      checkOutput({tag, "_ovf"}, ovf, eOvf);
   endtask

   function automatic logic [16:0] refOp(input logic m, input logic [15:0] a, input logic [15:0] b, input logic c);
      if (m) return {1'b0, a} + {1'b0, b} + {16'd0, c};
      else   return {1'b0, a} - {1'b0, b} - {16'd0, c};
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      int          sent;
      int          rcv;
      int          cyc;
      logic        prevHold;
      logic [15:0] heldDiff;
      logic [16:0] r;

      vm[0] = 1'b1; vx[0] = 16'h1111; vy[0] = 16'h2222; vb[0] = 1'b0;
      vm[1] = 1'b0; vx[1] = 16'h4000; vy[1] = 16'h4001; vb[1] = 1'b0;
      vm[2] = 1'b1; vx[2] = 16'hABCD; vy[2] = 16'h5432; vb[2] = 1'b1;
      vm[3] = 1'b0; vx[3] = 16'h0F0F; vy[3] = 16'h00FF; vb[3] = 1'b1;
      vm[4] = 1'b1; vx[4] = 16'h8000; vy[4] = 16'h8000; vb[4] = 1'b0;
      vm[5] = 1'b0; vx[5] = 16'h7777; vy[5] = 16'h1111; vb[5] = 1'b0;
      vm[6] = 1'b1; vx[6] = 16'h0001; vy[6] = 16'hFFFE; vb[6] = 1'b0;
      vm[7] = 1'b0; vx[7] = 16'hFFFF; vy[7] = 16'hFFFF; vb[7] = 1'b1;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      mode = 1'b0; x = '0; y = '0; bin = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_diff", diff, 0);
      checkOutput("rst_bout", bout, 0);
      checkOutput("rst_zero", zero, 0);
      checkOutput("rst_ovf", ovf, 0);

      applyStimulus(1'b0, 16'h1234, 16'h0235, 1'b0);
      waitResult("sub_basic", 16'h0FFF, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h5A5A, 16'h5A5A, 1'b0);
      waitResult("sub_equal", 16'h0000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 16'h0000, 16'h0001, 1'b0);
      waitResult("sub_ripple", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h0000, 16'h0001, 1'b1);
      waitResult("sub_ripple_bin", 16'hFFFE, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0);
      waitResult("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 16'h8000, 16'h0001, 1'b0);
      waitResult("sub_ovf", 16'h7FFF, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      waitResult("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      #1;

      sent = 0; rcv = 0; cyc = 0; prevHold = 1'b0; heldDiff = '0;
      while (rcv < 8 && cyc < 60) begin
         out_ready = !(cyc >= 6 && cyc <= 8);
         if (sent < 8) begin
            in_valid = 1'b1; mode = vm[sent]; x = vx[sent]; y = vy[sent]; bin = vb[sent];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (!out_ready && out_valid) checkOutput("bp_stall_ready", in_ready, 0);
         if (prevHold) checkOutput("bp_hold", diff, heldDiff);
         prevHold = out_valid && !out_ready;
         heldDiff = diff;
         if (out_valid && out_ready) begin
            r = refOp(vm[rcv], vx[rcv], vy[rcv], vb[rcv]);
            checkOutput("bp_diff", diff, r[15:0]);
            checkOutput("bp_bout", bout, r[16]);
            rcv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checkOutput("bp_count", rcv, 8);
      repeat (6) begin
         @(negedge clk);
         checkOutput("bp_extra", out_valid, 0);
      end
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; mode = 1'b0; x = 16'h1000 + 16'(i); y = 16'h0001; bin = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_mid_ready", in_ready, 1);
      repeat (8) begin
         @(negedge clk);
         checkOutput("rst_mid_flush", out_valid, 0);
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b1, 16'h1234, 16'h4321, 1'b1);
      waitResult("rst_mid_next", 16'h5556, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
